// File: rtl/mmio_bridge_fsm.sv
// mmio_bridge_fsm: registered CPU-to-MMIO bridge. Decodes the CPU access
// against per-slave base/mask windows and runs a req/ready handshake with the
// selected slave. Unmapped addresses and slave timeouts complete with an error.
module mmio_bridge_fsm #(
  parameter int                      NUM_SLV  = 4,
  parameter logic [32*NUM_SLV-1:0]   SLV_BASE = '0,
  parameter logic [32*NUM_SLV-1:0]   SLV_MASK = '0,
  parameter int                      TIMEOUT  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_byteen,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic [31:0]              cpu_rdata,
  output logic [NUM_SLV-1:0]       s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_byteen,
  input  logic [32*NUM_SLV-1:0]    s_rdata,
  input  logic [NUM_SLV-1:0]       s_ready
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 cpu_ack_reg;
  logic                 cpu_err_reg;
  logic [31:0]          cpu_rdata_reg;
  logic [NUM_SLV-1:0]   s_sel_reg;
  logic [31:0]          s_addr_reg;
  logic [31:0]          s_wdata_reg;
  logic [3:0]           s_byteen_reg;

  logic [NUM_SLV-1:0]   hit;
  logic [NUM_SLV-1:0]   sel_next;
  logic [31:0]          rdata_masked [NUM_SLV];
  logic [31:0]          rdata_sel;
  logic                 ready_sel;

  // Per-window address decode and read-data gating by the registered select
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign hit[gi]          = ((cpu_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32]);
      assign rdata_masked[gi] = s_rdata[32*gi +: 32] & {32{s_sel_reg[gi]}};
    end
  endgenerate

  // Priority select: scanning downwards lets the lowest-index hit win on overlap
  always_comb begin
    sel_next = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_next    = '0;
        sel_next[i] = 1'b1;
      end
    end
  end

  // Read data of the selected slave (select is one-hot, so OR is a mux)
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rdata_sel = rdata_sel | rdata_masked[i];
    end
  end

  assign ready_sel = |(s_ready & s_sel_reg);

  // Bridge FSM with all CPU and slave outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cpu_ack_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      s_sel_reg     <= '0;
      s_addr_reg    <= '0;
      s_wdata_reg   <= '0;
      s_byteen_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            s_addr_reg  <= cpu_addr;
            s_wdata_reg <= cpu_wdata;
            cnt_reg     <= '0;
            if (|hit) begin
              s_sel_reg    <= sel_next;
              s_byteen_reg <= cpu_byteen;
              state_reg    <= ACCESS;
            end else begin
              s_sel_reg    <= '0;
              s_byteen_reg <= '0;
              state_reg    <= ERR;
            end
          end
        end
        ACCESS: begin
          if (ready_sel) begin
            cpu_rdata_reg <= rdata_sel;
            cpu_ack_reg   <= 1'b1;
            cpu_err_reg   <= 1'b0;
            s_sel_reg     <= '0;
            s_byteen_reg  <= '0;
            state_reg     <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b1;
            cpu_err_reg   <= 1'b1;
            s_sel_reg     <= '0;
            s_byteen_reg  <= '0;
            state_reg     <= ERR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          cpu_ack_reg <= 1'b0;
          cpu_err_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        ERR: begin
          // A timeout enters with the ack already raised; an unmapped access
          // spends one silent cycle here so its ack lands two cycles after the
          // request, the same as the fastest mapped access.
          if (cpu_ack_reg) begin
            cpu_ack_reg <= 1'b0;
            cpu_err_reg <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            cpu_ack_reg   <= 1'b1;
            cpu_err_reg   <= 1'b1;
            cpu_rdata_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign cpu_err   = cpu_err_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign s_sel     = s_sel_reg;
  assign s_addr    = s_addr_reg;
  assign s_wdata   = s_wdata_reg;
  assign s_byteen  = s_byteen_reg;

endmodule

// File: tb/tb_mmio_bridge_fsm.sv
// tb_mmio_bridge_fsm: scoreboard bench for the MMIO bridge with a simple
// per-slave wait-state model.
module tb_mmio_bridge_fsm;

  localparam int NS = 4;
  localparam logic [32*NS-1:0] BASE = {32'h0000_7F00, 32'h0002_0000, 32'h0000_7F00, 32'h0000_0000};
  localparam logic [32*NS-1:0] MASK = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_C000};
  localparam int BOUND = 60;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cpu_req = 1'b0;
  logic [31:0]     cpu_addr = '0;
  logic [31:0]     cpu_wdata = '0;
  logic [3:0]      cpu_byteen = '0;
  logic            cpu_ack;
  logic            cpu_err;
  logic [31:0]     cpu_rdata;
  logic [NS-1:0]   s_sel;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_byteen;
  logic [32*NS-1:0] s_rdata;
  logic [NS-1:0]   s_ready = '0;

  logic [31:0] slv_data [NS];
  int          slv_wait [NS];
  logic        noise_en = 1'b0;
  int          wcnt = 0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          lat;
    logic [3:0]  sel;
    int          selcyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mmio_bridge_fsm #(
    .NUM_SLV (NS),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_byteen(cpu_byteen),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_byteen  (s_byteen),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready)
  );

  assign s_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

  // Slave model: selected slave raises ready after slv_wait[i] wait cycles
  // (-1 = never); unselected slaves show noise_en on their ready lines.
  always @(negedge clk) begin
    if (s_sel != '0) begin
      for (int i = 0; i < NS; i++) begin
        if (s_sel[i]) s_ready[i] = (slv_wait[i] >= 0) && (wcnt == slv_wait[i]);
        else          s_ready[i] = noise_en;
      end
      wcnt = wcnt + 1;
    end else begin
      wcnt = 0;
      for (int i = 0; i < NS; i++) s_ready[i] = noise_en;
    end
  end

  // Drive one access and report what the DUT did; cycle 1 is the cycle after
  // the edge that samples the request.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                            output int lat, output logic [3:0] sel_seen, output int sel_cyc,
                            output logic err, output logic [31:0] rdata,
                            output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                            output logic [3:0] be_seen, output logic ack_after);
    lat = -1; sel_seen = '0; sel_cyc = 0; err = 1'bx; rdata = 'x;
    addr_seen = '0; wdata_seen = '0; be_seen = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be;
    for (int c = 1; c <= BOUND; c++) begin
      @(negedge clk);
      if (s_sel != '0) begin
        sel_cyc++;
        sel_seen   = sel_seen | s_sel;
        addr_seen  = s_addr;
        wdata_seen = s_wdata;
        be_seen    = be_seen | s_byteen;
      end
      if (cpu_ack) begin
        lat = c; err = cpu_err; rdata = cpu_rdata;
        cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    ack_after = cpu_ack;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({cpu_ack, cpu_err} !== 2'b00) begin n_bad++; $display("FAIL reset_ack_err: got %b expected 00", {cpu_ack, cpu_err}); end
    n_vec++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    n_vec++; if ({s_sel, s_byteen} !== 8'h00) begin n_bad++; $display("FAIL reset_sel_be: got %h expected 00", {s_sel, s_byteen}); end
    n_vec++; if ({s_addr, s_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_addr_wdata: got %h expected 0", {s_addr, s_wdata}); end
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_write();
    int lat, sc; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    slv_wait[0] = 0;
    sb_q.push_back('{lat: 2, sel: 4'b0001, selcyc: 1, err: 1'b0, rdata: slv_data[0]});
    run_access(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, lat, sel, sc, err, rd, ad, wd, be, aa);
    e = sb_q.pop_front();
    $display("write 0x10: lat=%0d sel=%b err=%b", lat, sel, err);
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL write_lat: got %0d expected %0d", lat, e.lat); end
    n_vec++; if (sel !== e.sel || sc != e.selcyc) begin n_bad++; $display("FAIL write_sel: got %b/%0d expected %b/%0d", sel, sc, e.sel, e.selcyc); end
    n_vec++; if (err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL write_resp: got %b/%h expected %b/%h", err, rd, e.err, e.rdata); end
    n_vec++; if (ad !== 32'h10 || wd !== 32'hDEAD_BEEF || be !== 4'hF) begin n_bad++; $display("FAIL write_bus: got %h/%h/%h expected 10/deadbeef/f", ad, wd, be); end
    n_vec++; if (aa !== 1'b0) begin n_bad++; $display("FAIL write_ack_pulse: got %b expected 0", aa); end
  endtask

  task automatic test_read_wait();
    int lat, sc; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    slv_wait[1] = 3; noise_en = 1'b1;
    sb_q.push_back('{lat: 5, sel: 4'b0010, selcyc: 4, err: 1'b0, rdata: 32'h1234_5678});
    run_access(32'h0000_7F04, 32'h0, 4'b0000, lat, sel, sc, err, rd, ad, wd, be, aa);
    noise_en = 1'b0;
    e = sb_q.pop_front();
    $display("read 0x7F04: lat=%0d sel=%b rdata=%h", lat, sel, rd);
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL read_lat: got %0d expected %0d", lat, e.lat); end
    n_vec++; if (sel !== e.sel || sc != e.selcyc) begin n_bad++; $display("FAIL read_sel: got %b/%0d expected %b/%0d", sel, sc, e.sel, e.selcyc); end
    n_vec++; if (err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL read_resp: got %b/%h expected %b/%h", err, rd, e.err, e.rdata); end
    n_vec++; if (be !== 4'h0) begin n_bad++; $display("FAIL read_byteen: got %h expected 0", be); end
  endtask

  task automatic test_unmapped();
    int lat, sc; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    sb_q.push_back('{lat: 2, sel: 4'b0000, selcyc: 0, err: 1'b1, rdata: 32'h0});
    run_access(32'h0000_9000, 32'h0, 4'b0000, lat, sel, sc, err, rd, ad, wd, be, aa);
    e = sb_q.pop_front();
    $display("unmapped 0x9000: lat=%0d sel=%b err=%b", lat, sel, err);
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL unmapped_lat: got %0d expected %0d", lat, e.lat); end
    n_vec++; if (sel !== e.sel || sc != e.selcyc) begin n_bad++; $display("FAIL unmapped_sel: got %b/%0d expected %b/%0d", sel, sc, e.sel, e.selcyc); end
    n_vec++; if (err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL unmapped_resp: got %b/%h expected %b/%h", err, rd, e.err, e.rdata); end
    n_vec++; if (aa !== 1'b0) begin n_bad++; $display("FAIL unmapped_ack_pulse: got %b expected 0", aa); end
  endtask

  task automatic test_timeout();
    int lat, sc; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    for (int k = 0; k < 2; k++) begin
      slv_wait[2] = (k == 0) ? -1 : 15;
      sb_q.push_back('{lat: 17, sel: 4'b0100, selcyc: 16, err: (k == 0), rdata: (k == 0) ? 32'h0 : slv_data[2]});
      run_access(32'h0002_0000, 32'h0, 4'b0000, lat, sel, sc, err, rd, ad, wd, be, aa);
      e = sb_q.pop_front();
      $display("timeout case %0d: lat=%0d selcyc=%0d err=%b rdata=%h", k, lat, sc, err, rd);
      n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL timeout%0d_lat: got %0d expected %0d", k, lat, e.lat); end
      n_vec++; if (sel !== e.sel || sc != e.selcyc) begin n_bad++; $display("FAIL timeout%0d_sel: got %b/%0d expected %b/%0d", k, sel, sc, e.sel, e.selcyc); end
      n_vec++; if (err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL timeout%0d_resp: got %b/%h expected %b/%h", k, err, rd, e.err, e.rdata); end
    end
  endtask

  task automatic test_overlap();
    int lat, sc; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    logic [31:0] addrs [2];
    logic [3:0]  sels  [2];
    addrs[0] = 32'h0000_7F08; sels[0] = 4'b0010;
    addrs[1] = 32'h0000_7F80; sels[1] = 4'b1000;
    slv_wait[1] = 0; slv_wait[3] = 1;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{lat: (k == 0) ? 2 : 3, sel: sels[k], selcyc: (k == 0) ? 1 : 2, err: 1'b0,
                       rdata: (k == 0) ? slv_data[1] : slv_data[3]});
      run_access(addrs[k], 32'h5555_AAAA, 4'b0011, lat, sel, sc, err, rd, ad, wd, be, aa);
      e = sb_q.pop_front();
      $display("overlap %h: sel=%b rdata=%h", addrs[k], sel, rd);
      n_vec++; if (sel !== e.sel || sc != e.selcyc || lat != e.lat) begin n_bad++; $display("FAIL overlap%0d_sel: got %b/%0d/%0d expected %b/%0d/%0d", k, sel, sc, lat, e.sel, e.selcyc, e.lat); end
      n_vec++; if (err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL overlap%0d_resp: got %b/%h expected %b/%h", k, err, rd, e.err, e.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    int acks; exp_t e;
    slv_wait[0] = 0;
    for (int k = 0; k < 4; k++) sb_q.push_back('{lat: 2 + 3*k, sel: 4'b0001, selcyc: 1, err: 1'b0, rdata: slv_data[0]});
    acks = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h0; cpu_byteen = 4'h0;
    for (int c = 1; c <= BOUND && acks < 4; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        e = sb_q.pop_front();
        acks++;
        if (acks == 4) cpu_req = 1'b0;
        $display("back-to-back ack %0d at cycle %0d err=%b", acks, c, cpu_err);
        n_vec++; if (c != e.lat || cpu_err !== e.err || cpu_rdata !== e.rdata) begin n_bad++; $display("FAIL b2b_ack%0d: got c=%0d %b/%h expected c=%0d %b/%h", acks, c, cpu_err, cpu_rdata, e.lat, e.err, e.rdata); end
      end
    end
    cpu_req = 1'b0;
    n_vec++; if (acks != 4) begin n_bad++; $display("FAIL b2b_count: got %0d expected 4", acks); end
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, sc, stray; logic [3:0] sel, be; logic err, aa; logic [31:0] rd, ad, wd; exp_t e;
    slv_wait[2] = -1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0002_0040; cpu_wdata = 32'hCAFE_0001; cpu_byteen = 4'b1111;
    repeat (3) @(negedge clk);
    n_vec++; if (s_sel !== 4'b0100) begin n_bad++; $display("FAIL midreset_pre_sel: got %b expected 0100", s_sel); end
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    $display("reset during access");
    n_vec++; if ({cpu_ack, cpu_err, s_sel, s_byteen} !== 10'h0 || {cpu_rdata, s_addr, s_wdata} !== 96'h0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b %h expected all 0", {cpu_ack, cpu_err, s_sel, s_byteen}, {cpu_rdata, s_addr, s_wdata}); end
    reset = 1'b1;
    stray = 0;
    repeat (4) begin @(negedge clk); if (cpu_ack) stray++; end
    n_vec++; if (stray != 0) begin n_bad++; $display("FAIL midreset_stray_ack: got %0d expected 0", stray); end
    slv_wait[0] = 0;
    sb_q.push_back('{lat: 2, sel: 4'b0001, selcyc: 1, err: 1'b0, rdata: slv_data[0]});
    run_access(32'h0000_0020, 32'h0, 4'b0000, lat, sel, sc, err, rd, ad, wd, be, aa);
    e = sb_q.pop_front();
    $display("post-reset read: lat=%0d sel=%b err=%b", lat, sel, err);
    n_vec++; if (lat != e.lat || sel !== e.sel || err !== e.err || rd !== e.rdata) begin
      n_bad++; $display("FAIL postreset_access: got %0d/%b/%b/%h expected %0d/%b/%b/%h", lat, sel, err, rd, e.lat, e.sel, e.err, e.rdata); end
  endtask

  initial begin
    slv_data[0] = 32'hA0A0_A0A0; slv_data[1] = 32'h1234_5678;
    slv_data[2] = 32'hC0FF_EE02; slv_data[3] = 32'h3333_3333;
    for (int i = 0; i < NS; i++) slv_wait[i] = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
